traffic_input_conditioner: RTL and testbench

TRAFFIC_INPUT_CONDITIONER -- requirements
Module: traffic_input_conditioner

---
 rtl/traffic_input_conditioner_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 37 +++
 rtl/traffic_input_conditioner.sv | 142 ++++++++++++++
 tb/tb_traffic_input_conditioner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_input_conditioner_pkg.sv
// Shared traffic definitions: emergency FSM encoding, parameter defaults and
// the priority helper used by the input conditioner.
package traffic_input_conditioner_pkg;

    localparam int unsigned DEF_SHORT_CYC = 5;
    localparam int unsigned DEF_LONG_CYC  = 15;
    localparam int unsigned DEF_DEB_CYC   = 4;
    localparam int unsigned DEF_EMG_HOLD  = 20;
    localparam int unsigned NUM_LINES     = 4;

    typedef enum logic [0:0] {
        EMG_IDLE  = 1'b0,
        EMG_GRANT = 1'b1
    } emg_state_t;

    // One-hot of the lowest set bit; line 1 (bit 0) has the highest priority.
    function automatic logic [NUM_LINES-1:0] lowest_set(input logic [NUM_LINES-1:0] req);
        return req & (~req + NUM_LINES'(1));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counter debouncer for one raw button.
module btn_debounce
    import traffic_input_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEF_DEB_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic state
);

    localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Count consecutive synchronized samples that disagree with the debounced state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            state  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            if (sync_q[1] == state) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                state <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_input_conditioner.sv
// Conditions four emergency buttons into one-at-a-time held requests and
// provides the short/long phase interval flags to the traffic controller.
module traffic_input_conditioner
    import traffic_input_conditioner_pkg::*;
#(
    parameter int unsigned SHORT_CYC = DEF_SHORT_CYC,
    parameter int unsigned LONG_CYC  = DEF_LONG_CYC,
    parameter int unsigned DEB_CYC   = DEF_DEB_CYC,
    parameter int unsigned EMG_HOLD  = DEF_EMG_HOLD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn1,
    input  logic btn2,
    input  logic btn3,
    input  logic btn4,
    input  logic phase_start,
    output logic sw1,
    output logic sw2,
    output logic sw3,
    output logic sw4,
    output logic ts,
    output logic tl
);

    localparam int unsigned CNT_W  = $clog2(LONG_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(EMG_HOLD + 1);

    logic [NUM_LINES-1:0] btn_raw;
    logic [NUM_LINES-1:0] deb;
    logic [NUM_LINES-1:0] deb_q;
    logic [NUM_LINES-1:0] rise_c;
    logic [NUM_LINES-1:0] pending_q;
    logic [NUM_LINES-1:0] clr_c;
    logic [NUM_LINES-1:0] sw_q;
    logic [NUM_LINES-1:0] sw_d;
    emg_state_t           state_q;
    emg_state_t           state_d;
    logic [HOLD_W-1:0]    hold_q;
    logic [HOLD_W-1:0]    hold_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;

    assign btn_raw = {btn4, btn3, btn2, btn1};

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_deb
        btn_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_btn_debounce (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw[i]),
            .state (deb[i])
        );
    end

    // Only debounced presses queue a request; releases are ignored.
    assign rise_c = deb & ~deb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q     <= '0;
            pending_q <= '0;
        end else begin
            deb_q     <= deb;
            pending_q <= (pending_q & ~clr_c) | rise_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMG_IDLE;
            hold_q  <= '0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sw_q    <= sw_d;
        end
    end

    // Grant the highest-priority pending line and hold it without preemption.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sw_d    = sw_q;
        clr_c   = '0;
        case (state_q)
            EMG_IDLE: begin
                sw_d = '0;
                if (|pending_q) begin
                    state_d = EMG_GRANT;
                    hold_d  = HOLD_W'(EMG_HOLD);
                    sw_d    = lowest_set(pending_q);
                    clr_c   = lowest_set(pending_q);
                end
            end
            EMG_GRANT: begin
                if (hold_q == HOLD_W'(1)) begin
                    state_d = EMG_IDLE;
                    hold_d  = '0;
                    sw_d    = '0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = EMG_IDLE;
                hold_d  = '0;
                sw_d    = '0;
            end
        endcase
    end

    // Phase timer is held at zero for the whole emergency grant.
    always_comb begin
        count_d = count_q;
        if (phase_start || (state_d == EMG_GRANT)) begin
            count_d = '0;
        end else if (count_q != CNT_W'(LONG_CYC)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ts      <= 1'b0;
            tl      <= 1'b0;
        end else begin
            count_q <= count_d;
            ts      <= (count_d >= CNT_W'(SHORT_CYC));
            tl      <= (count_d >= CNT_W'(LONG_CYC));
        end
    end

    assign sw1 = sw_q[0];
    assign sw2 = sw_q[1];
    assign sw3 = sw_q[2];
    assign sw4 = sw_q[3];

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed and randomized checks of traffic_input_conditioner against a
// cycle-level behavioural model of the button and timer rules.
module tb_traffic_input_conditioner;

    localparam int unsigned SHORT_CYC = 5;
    localparam int unsigned LONG_CYC  = 15;
    localparam int unsigned DEB_CYC   = 4;
    localparam int unsigned EMG_HOLD  = 20;

    logic clk         = 1'b0;
    logic reset       = 1'b0;
    logic btn1        = 1'b0;
    logic btn2        = 1'b0;
    logic btn3        = 1'b0;
    logic btn4        = 1'b0;
    logic phase_start = 1'b0;
    logic sw1, sw2, sw3, sw4, ts, tl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_input_conditioner #(
        .SHORT_CYC (SHORT_CYC),
        .LONG_CYC  (LONG_CYC),
        .DEB_CYC   (DEB_CYC),
        .EMG_HOLD  (EMG_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn1        (btn1),
        .btn2        (btn2),
        .btn3        (btn3),
        .btn4        (btn4),
        .phase_start (phase_start),
        .sw1         (sw1),
        .sw2         (sw2),
        .sw3         (sw3),
        .sw4         (sw4),
        .ts          (ts),
        .tl          (tl)
    );

    // Behavioural model: raw sample history, run lengths, request set, grant line.
    int hist [4][2];
    bit m_deb  [4];
    int m_run  [4];
    bit m_rose [4];
    bit m_pend [4];
    int m_gnt  = 0;
    int m_left = 0;
    int m_cnt  = 0;

    always @(posedge clk or posedge reset) begin : model
        bit raw [4];
        int first;
        int clr;
        bit s;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hist[i][0] = 0;
                hist[i][1] = 0;
                m_deb[i]   = 0;
                m_run[i]   = 0;
                m_rose[i]  = 0;
                m_pend[i]  = 0;
            end
            m_gnt  = 0;
            m_left = 0;
            m_cnt  = 0;
        end else begin
            raw[0] = btn1;
            raw[1] = btn2;
            raw[2] = btn3;
            raw[3] = btn4;
            first = 0;
            for (int i = 3; i >= 0; i--) if (m_pend[i]) first = i + 1;
            clr = 0;
            if (m_gnt != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_gnt = 0;
            end else if (first != 0) begin
                m_gnt  = first;
                m_left = EMG_HOLD;
                clr    = first;
            end
            for (int i = 0; i < 4; i++) begin
                if (clr == i + 1) m_pend[i] = 0;
                if (m_rose[i]) m_pend[i] = 1;
                m_rose[i] = 0;
                s = hist[i][1] != 0;
                if (s != m_deb[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB_CYC) begin
                        m_deb[i]  = s;
                        m_run[i]  = 0;
                        m_rose[i] = s;
                    end
                end else begin
                    m_run[i] = 0;
                end
                hist[i][1] = hist[i][0];
                hist[i][0] = raw[i];
            end
            if (phase_start || m_gnt != 0) m_cnt = 0;
            else if (m_cnt < LONG_CYC) m_cnt = m_cnt + 1;
        end
    end

    function automatic logic [7:0] sw_vec();
        return {4'b0, sw4, sw3, sw2, sw1};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] e_sw;
        logic [7:0] e_t;
        @(posedge clk);
        @(negedge clk);
        e_sw = (m_gnt == 0) ? 8'h00 : 8'(1 << (m_gnt - 1));
        e_t  = {6'b0, m_cnt >= LONG_CYC, m_cnt >= SHORT_CYC};
        check("sw_model", sw_vec(), e_sw);
        check("timer_model", {6'b0, tl, ts}, e_t);
    endtask

    initial begin
        int n;
        bit seen;
        logic [7:0] rec [64];
        logic [3:0] b;

        reset = 1'b1;
        @(negedge clk);
        check("reset_sw", sw_vec(), 8'h00);
        check("reset_timer", {6'b0, tl, ts}, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // phase timer thresholds and clear
        phase_start = 1'b1;
        tick();
        phase_start = 1'b0;
        repeat (4) tick();
        check("ts_before_short", {7'b0, ts}, 8'h00);
        tick();
        check("ts_at_short", {6'b0, tl, ts}, 8'h01);
        repeat (9) tick();
        check("tl_before_long", {6'b0, tl, ts}, 8'h01);
        tick();
        check("tl_at_long", {6'b0, tl, ts}, 8'h03);
        repeat (3) tick();
        phase_start = 1'b1;
        tick();
        phase_start = 1'b0;
        check("second_phase_clear", {6'b0, tl, ts}, 8'h00);

        // phase_start coinciding with the short threshold
        repeat (4) tick();
        phase_start = 1'b1;
        tick();
        phase_start = 1'b0;
        check("clear_wins_at_short", {7'b0, ts}, 8'h00);
        repeat (4) tick();
        check("recount_below_short", {7'b0, ts}, 8'h00);
        tick();
        check("recount_at_short", {7'b0, ts}, 8'h01);

        // clean btn2 press
        btn2 = 1'b1;
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            tick();
            if (sw2) n = k;
        end
        check("sw2_latency", 8'(n), 8'd8);
        n = 1;
        seen = 0;
        for (int k = 9; k <= 45; k++) begin
            if (k == 30) btn2 = 1'b0;
            tick();
            if (sw2) n++;
            if (sw1 || sw3 || sw4) seen = 1;
        end
        check("sw2_width", 8'(n), 8'd20);
        check("sw2_others_low", 8'(seen), 8'h00);

        // bouncing btn1 never settles
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            btn1 = ((k % 4) < 2);
            tick();
            if (sw_vec() != 8'h00) seen = 1;
        end
        btn1 = 1'b0;
        repeat (20) begin
            tick();
            if (sw_vec() != 8'h00) seen = 1;
        end
        check("bounce_no_grant", 8'(seen), 8'h00);

        // simultaneous btn1 and btn3
        btn1 = 1'b1;
        btn3 = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            if (k == 31) begin
                btn1 = 1'b0;
                btn3 = 1'b0;
            end
            tick();
            rec[k] = sw_vec();
        end
        check("dual_sw1_pre", rec[7], 8'h00);
        check("dual_sw1_start", rec[8], 8'h01);
        check("dual_sw1_end", rec[27], 8'h01);
        check("dual_gap", rec[28], 8'h00);
        check("dual_sw3_start", rec[29], 8'h04);
        check("dual_sw3_end", rec[48], 8'h04);
        check("dual_sw3_off", rec[49], 8'h00);

        // reset during an sw4 grant with btn2 pending
        btn4 = 1'b1;
        n = 0;
        for (int k = 1; k <= 20 && n == 0; k++) begin
            tick();
            if (sw4) n = k;
        end
        check("sw4_latency", 8'(n), 8'd8);
        btn2 = 1'b1;
        repeat (10) tick();
        check("sw4_held", sw_vec(), 8'h08);
        #2 reset = 1'b1;
        #1;
        check("sw_async_reset", sw_vec(), 8'h00);
        btn2 = 1'b0;
        btn4 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (sw_vec() != 8'h00) seen = 1;
        end
        check("post_reset_no_grant", 8'(seen), 8'h00);

        // randomized buttons and phase pulses against the model
        b = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 15) == 0) b[i] = ~b[i];
            end
            {btn4, btn3, btn2, btn1} = b;
            phase_start = ($urandom_range(0, 11) == 0);
            tick();
        end
        {btn4, btn3, btn2, btn1} = 4'b0;
        phase_start = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
